// File: rtl/nnet_requant_pkg.sv
// Shared widths, int8 limits and the output-stage payload for the requantizer.
package nnet_requant_pkg;

  localparam int PROD_W    = 48;
  localparam int RND_W     = 49;
  localparam int INT8_MAX  = 127;
  localparam int INT8_MIN  = -128;
  localparam int MAX_SHIFT = 47;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       sat;
  } stage_t;

endpackage

// File: rtl/nnet_requant_sat8.sv
// Combinational ReLU, zero-point add and int8 clamp for the final pipeline stage.
module nnet_requant_sat8
  import nnet_requant_pkg::*;
(
  input  logic signed [RND_W-1:0] q,
  input  logic                    relu,
  input  logic signed [7:0]       zp,
  output logic [7:0]              dout,
  output logic                    sat
);

  // One extra bit so the zero-point add can never wrap.
  localparam int SW = RND_W + 1;
  localparam logic signed [SW-1:0] HI = SW'(INT8_MAX);
  localparam logic signed [SW-1:0] LO = SW'(INT8_MIN);

  logic signed [SW-1:0] qr;
  logic signed [SW-1:0] s;

  always_comb begin
    qr = (relu && q[RND_W-1]) ? '0 : SW'(q);
    s  = qr + SW'(zp);
    sat  = 1'b0;
    dout = s[7:0];
    if (s > HI) begin
      dout = 8'(INT8_MAX);
      sat  = 1'b1;
    end else if (s < LO) begin
      dout = 8'(INT8_MIN);
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/nnet_requant_acc32_s8.sv
// Three-stage requantizer: int32 accumulator -> scale, round-shift, relu/zp/clamp -> int8.
module nnet_requant_acc32_s8
  import nnet_requant_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [ACC_WIDTH-1:0]   din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [7:0]             dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic [7:0]             cfg_zp,
  input  logic                   cfg_relu,
  input  logic                   sat_clr,
  output logic [CNT_WIDTH-1:0]   sat_cnt,
  output logic                   idle
);

  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [SHIFT_WIDTH-1:0] SHIFT_LIM = SHIFT_WIDTH'(MAX_SHIFT);

  logic                      v1, v2;
  logic signed [PROD_W-1:0]  p1;
  logic signed [RND_W-1:0]   q2;
  stage_t                    s3;
  logic                      en1, en2, en3;

  logic signed [PROD_W-1:0]  din_ext, scale_ext, p_next;
  logic [SHIFT_WIDTH-1:0]    shift_eff;
  logic signed [RND_W-1:0]   rnd, r, q_next;
  logic [7:0]                sat_dout;
  logic                      sat_flag;

  // Each stage loads when empty or when its current contents move on.
  assign en3       = ~s3.valid | dout_ready;
  assign en2       = ~v2 | en3;
  assign en1       = ~v1 | en2;
  assign din_ready = en1;

  assign din_ext   = PROD_W'($signed(din));
  assign scale_ext = PROD_W'({1'b0, cfg_scale});
  assign p_next    = din_ext * scale_ext;

  // Illegal shifts are clamped so hardware behaviour stays bounded.
  assign shift_eff = (cfg_shift > SHIFT_LIM) ? SHIFT_LIM : cfg_shift;
  assign rnd       = (shift_eff == '0) ? '0 : (RND_W'(1) << (shift_eff - SHIFT_WIDTH'(1)));
  assign r         = RND_W'(p1) + rnd;
  assign q_next    = r >>> shift_eff;

  nnet_requant_sat8 u_sat8 (
    .q    (q2),
    .relu (cfg_relu),
    .zp   (cfg_zp),
    .dout (sat_dout),
    .sat  (sat_flag)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      p1 <= '0;
      q2 <= '0;
      s3 <= '0;
    end else begin
      if (en1) begin
        v1 <= din_valid;
        if (din_valid) p1 <= p_next;
      end
      if (en2) begin
        v2 <= v1;
        if (v1) q2 <= q_next;
      end
      if (en3) begin
        s3.valid <= v2;
        if (v2) begin
          s3.data <= sat_dout;
          s3.sat  <= sat_flag;
        end
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (s3.valid && dout_ready && s3.sat && sat_cnt != CNT_MAX) begin
      sat_cnt <= sat_cnt + CNT_WIDTH'(1);
    end
  end

  assign dout       = s3.data;
  assign dout_valid = s3.valid;
  assign idle       = ~(v1 | v2 | s3.valid);

  a_shift_legal: assert property (@(posedge ap_clk) disable iff (ap_rst) cfg_shift <= SHIFT_LIM)
    else $error("cfg_shift above 47");

endmodule

// File: tb/tb_nnet_requant_acc32_s8.sv
// Directed-vector bench for the int32 -> int8 requantizer.
module tb_nnet_requant_acc32_s8;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [15:0] cfg_scale = '0;
  logic [5:0]  cfg_shift = '0;
  logic [7:0]  cfg_zp = '0;
  logic        cfg_relu = 1'b0;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;
  logic        idle;

  int n_checks = 0;
  int n_pass   = 0;

  nnet_requant_acc32_s8 dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .cfg_scale  (cfg_scale),
    .cfg_shift  (cfg_shift),
    .cfg_zp     (cfg_zp),
    .cfg_relu   (cfg_relu),
    .sat_clr    (sat_clr),
    .sat_cnt    (sat_cnt),
    .idle       (idle)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_cfg(input int scale, input int shift, input int zp, input logic relu);
    @(negedge ap_clk);
    cfg_scale = 16'(scale);
    cfg_shift = 6'(shift);
    cfg_zp    = 8'(zp);
    cfg_relu  = relu;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    dout_ready = 1'b1;
    while (!idle && n < 20) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check_val(tag, int'(idle), 1);
  endtask

  // One isolated beat; latency counts edges from the accepting edge inclusive.
  task automatic run_beat(input string tag, input int d, input int exp);
    int lat;
    @(negedge ap_clk);
    din = 32'(d);
    din_valid = 1'b1;
    dout_ready = 1'b1;
    @(posedge ap_clk); #1;
    din_valid = 1'b0;
    lat = 1;
    while (!dout_valid && lat < 10) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    check_val({tag, "_lat"}, lat, 3);
    check_val(tag, int'($signed(dout)), exp);
  endtask

  initial begin
    int sent, got, inflight, cyc;
    logic stall_prev, acc, xfer;
    logic [7:0] held;
    logic [31:0] pat;

    #2 ap_rst = 1'b1;
    #1;
    check_val("rst_dout_valid", int'(dout_valid), 0);
    check_val("rst_dout", int'(dout), 0);
    check_val("rst_sat_cnt", int'(sat_cnt), 0);
    check_val("rst_idle", int'(idle), 1);
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    check_val("rst_din_ready", int'(din_ready), 1);

    // Rounding: scale 2^14, shift 15 gives floor((din+1)/2)
    set_cfg(16384, 15, 0, 1'b0);
    run_beat("rnd_200", 200, 100);
    run_beat("rnd_201", 201, 101);
    run_beat("rnd_m201", -201, -100);
    drain("rnd_drain");
    check_val("rnd_sat_cnt", int'(sat_cnt), 0);

    run_beat("sat_hi", 1000, 127);
    run_beat("sat_lo", -1000, -128);
    drain("sat_drain");
    check_val("sat_cnt_2", int'(sat_cnt), 2);
    run_beat("sat_hi2", 2000, 127);
    @(negedge ap_clk);
    sat_clr = 1'b1;
    @(posedge ap_clk); #1;
    sat_clr = 1'b0;
    check_val("sat_clr_wins", int'(sat_cnt), 0);
    check_val("sat_clr_idle", int'(idle), 1);

    set_cfg(16384, 15, 5, 1'b1);
    run_beat("relu_neg", -201, 5);
    run_beat("relu_pos", 200, 105);
    drain("relu_drain");
    set_cfg(16384, 15, -128, 1'b1);
    run_beat("zp_min", -201, -128);
    drain("zp_drain");
    check_val("zp_min_nosat", int'(sat_cnt), 0);

    set_cfg(1, 0, 0, 1'b0);
    run_beat("sh0_127", 127, 127);
    run_beat("sh0_128", 128, 127);
    run_beat("sh0_m129", -129, -128);
    drain("sh0_drain");
    check_val("sh0_sat_cnt", int'(sat_cnt), 2);

    // Backpressure: stream 10*i with a fixed ready pattern (starts with a 4-cycle stall)
    pat = 32'hA5C3_4D30;
    sent = 0; got = 0; inflight = 0; cyc = 0;
    stall_prev = 1'b0; held = '0;
    while (got < 10 && cyc < 400) begin
      @(negedge ap_clk);
      if (stall_prev) begin
        check_val("bp_hold_valid", int'(dout_valid), 1);
        check_val("bp_hold_data", int'(dout), int'(held));
      end
      dout_ready = pat[cyc % 32];
      din_valid = (sent < 10);
      din = 32'(10 * sent);
      #1;
      check_val("bp_din_ready", int'(din_ready), (inflight == 3 && !dout_ready) ? 0 : 1);
      acc  = din_valid & din_ready;
      xfer = dout_valid & dout_ready;
      if (xfer) begin
        check_val("bp_data", int'($signed(dout)), 10 * got);
        got++;
      end
      stall_prev = dout_valid & ~dout_ready;
      held = dout;
      if (acc) sent++;
      inflight = inflight + int'(acc) - int'(xfer);
      @(posedge ap_clk);
      cyc++;
    end
    @(negedge ap_clk);
    din_valid = 1'b0;
    check_val("bp_received", got, 10);
    check_val("bp_sent", sent, 10);
    drain("bp_drain");
    check_val("bp_no_extra", int'(dout_valid), 0);
    check_val("pre_rst_sat_cnt", int'(sat_cnt), 2);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      din = 32'(7 + i);
      din_valid = 1'b1;
      dout_ready = 1'b1;
      @(posedge ap_clk);
    end
    #1;
    check_val("inflight_valid", int'(dout_valid), 1);
    check_val("inflight_idle", int'(idle), 0);
    #1 ap_rst = 1'b1;
    #1;
    din_valid = 1'b0;
    check_val("mid_rst_dout_valid", int'(dout_valid), 0);
    check_val("mid_rst_sat_cnt", int'(sat_cnt), 0);
    check_val("mid_rst_idle", int'(idle), 1);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    run_beat("post_rst", 55, 55);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
